uart_rx_ctrl: RTL and testbench

- Frame-sequencing controller for the UART receiver.
- Owns the oversampling edge counter and bit counter.
- Issues enable strobes to the data sampler, start/parity/stop checkers and deserializer, then collects their error verdicts.
- Emits a one-cycle data_valid, parity_error or framing_error per received frame.

---
 rtl/uart_rx_ctrl.sv | 114 +++++++++++
 tb/tb_uart_rx_ctrl.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_ctrl.sv
// UART receive frame sequencer: runs the oversampling edge/bit counters, strobes the
// sampler, checkers and deserializer, and turns their verdicts into one result pulse.
//
// state  | meaning
// IDLE   | line idle, waiting for rx_in low
// START  | start bit, start checker enabled
// DATA   | data bits, one deserializer shift per bit
// PARITY | parity bit, parity checker enabled
// STOP   | stop bit, result pulse at mid-bit + 3
module uart_rx_ctrl #(
  parameter int DATA_WIDTH = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_in,
  input  logic       par_en,
  input  logic [5:0] prescale,
  input  logic       strt_glitch,
  input  logic       par_err,
  input  logic       stop_err,
  output logic [4:0] edge_count,
  output logic [3:0] bit_count,
  output logic       edge_cnt_en,
  output logic       dat_samp_en,
  output logic       strt_chk_en,
  output logic       par_chk_en,
  output logic       stp_chk_en,
  output logic       deser_en,
  output logic       data_valid,
  output logic       parity_error,
  output logic       framing_error
);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  localparam logic [3:0] LAST_DATA = 4'(DATA_WIDTH);

  state_t     state;
  state_t     state_nxt;
  logic       par_fail;
  logic [5:0] edge_ext;
  logic [5:0] half;
  logic       at_last;
  logic       at_deser;
  logic       at_verdict;

  assign edge_ext   = {1'b0, edge_count};
  assign half       = {1'b0, prescale[5:1]};
  assign at_last    = (edge_ext == prescale - 6'd1);
  assign at_deser   = (edge_ext == half + 6'd2);
  assign at_verdict = (edge_ext == half + 6'd3);

  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (!rx_in)   state_nxt = START;
      START:   if (at_last)  state_nxt = strt_glitch ? IDLE : DATA;
      DATA:    if (at_last && bit_count == LAST_DATA)
                 state_nxt = par_en ? PARITY : STOP;
      PARITY:  if (at_last)  state_nxt = STOP;
      STOP:    if (at_verdict) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // The IDLE cycle that sees rx_in low is edge 0 of the start bit.
  always_ff @(posedge clk) begin
    if (!rst) begin
      edge_count <= '0;
      bit_count  <= '0;
    end else if (state == IDLE) begin
      edge_count <= rx_in ? 5'd0 : 5'd1;
      bit_count  <= '0;
    end else if (state_nxt == IDLE) begin
      edge_count <= '0;
      bit_count  <= '0;
    end else if (at_last) begin
      edge_count <= '0;
      bit_count  <= bit_count + 4'd1;
    end else begin
      edge_count <= edge_count + 5'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst)                              par_fail <= 1'b0;
    else if (state == IDLE && !rx_in)      par_fail <= 1'b0;
    else if (state == PARITY && at_last)   par_fail <= par_err;
  end

  always_comb begin
    edge_cnt_en   = (state != IDLE);
    dat_samp_en   = (state != IDLE);
    strt_chk_en   = (state == START);
    par_chk_en    = (state == PARITY);
    stp_chk_en    = (state == STOP);
    deser_en      = (state == DATA) && at_deser;
    data_valid    = 1'b0;
    parity_error  = 1'b0;
    framing_error = 1'b0;
    // Decided mid-stop-bit so a start bit right after the stop bit is still caught.
    if (state == STOP && at_verdict) begin
      if (par_fail && par_en) parity_error  = 1'b1;
      else if (stop_err)      framing_error = 1'b1;
      else                    data_valid    = 1'b1;
    end
  end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Bench for uart_rx_ctrl: frame-offset model checked every cycle plus literal timing checks.
module tb_uart_rx_ctrl;
  localparam int DW = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       rx_in = 1'b1;
  logic       par_en = 1'b0;
  logic [5:0] prescale = 6'd8;
  logic       strt_glitch = 1'b0;
  logic       par_err = 1'b0;
  logic       stop_err = 1'b0;
  logic [4:0] edge_count;
  logic [3:0] bit_count;
  logic       edge_cnt_en, dat_samp_en, strt_chk_en, par_chk_en, stp_chk_en, deser_en;
  logic       data_valid, parity_error, framing_error;

  uart_rx_ctrl #(.DATA_WIDTH(DW)) dut (
    .clk(clk), .rst(rst), .rx_in(rx_in), .par_en(par_en), .prescale(prescale),
    .strt_glitch(strt_glitch), .par_err(par_err), .stop_err(stop_err),
    .edge_count(edge_count), .bit_count(bit_count), .edge_cnt_en(edge_cnt_en),
    .dat_samp_en(dat_samp_en), .strt_chk_en(strt_chk_en), .par_chk_en(par_chk_en),
    .stp_chk_en(stp_chk_en), .deser_en(deser_en), .data_valid(data_valid),
    .parity_error(parity_error), .framing_error(framing_error)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_pass = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 'h%0h expected 'h%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Model state: frame offset k counted from the IDLE cycle that saw rx_in low.
  logic checking = 1'b0;
  logic m_act = 1'b0;
  logic m_pf = 1'b0;
  logic m_pe = 1'b0;
  int   m_k = 0;
  int   m_p = 8;

  int dv_q[$];
  int pe_q[$];
  int fe_q[$];
  int ds_q[$];
  int fe_edge = -1;
  int fe_bit = -1;

  always @(negedge clk) begin
    int b, e, h, sb;
    logic [4:0] x_edge;
    logic [3:0] x_bit;
    logic x_en, x_strt, x_par, x_stp, x_des, x_dv, x_pe, x_fe;
    logic [18:0] expv, actv;
    b = 0; e = 0; h = 0; sb = 0;
    x_edge = '0; x_bit = '0;
    x_en = 0; x_strt = 0; x_par = 0; x_stp = 0; x_des = 0; x_dv = 0; x_pe = 0; x_fe = 0;
    if (checking) begin
      if (m_act) begin
        b  = m_k / m_p;
        e  = m_k % m_p;
        h  = m_p / 2;
        sb = DW + 1 + (m_pe ? 1 : 0);
        x_edge = 5'(e);
        x_bit  = 4'(b);
        x_en   = 1;
        x_strt = (b == 0);
        x_par  = m_pe && (b == DW + 1);
        x_stp  = (b == sb);
        x_des  = (b >= 1) && (b <= DW) && (e == h + 2);
        if (b == sb && e == h + 3) begin
          if (m_pe && m_pf) x_pe = 1;
          else if (stop_err) x_fe = 1;
          else x_dv = 1;
        end
      end
      expv = {x_edge, x_bit, x_en, x_en, x_strt, x_par, x_stp, x_des, x_dv, x_pe, x_fe};
      actv = {edge_count, bit_count, edge_cnt_en, dat_samp_en, strt_chk_en, par_chk_en,
              stp_chk_en, deser_en, data_valid, parity_error, framing_error};
      check("cycle_outputs", 32'(actv), 32'(expv));

      if (data_valid) dv_q.push_back(cyc);
      if (parity_error) pe_q.push_back(cyc);
      if (deser_en) ds_q.push_back(cyc);
      if (framing_error) begin
        fe_q.push_back(cyc);
        fe_edge = int'(edge_count);
        fe_bit  = int'(bit_count);
      end

      if (!rst) m_act = 0;
      else if (!m_act) begin
        if (!rx_in) begin
          m_act = 1; m_k = 1; m_pf = 0; m_p = int'(prescale); m_pe = par_en;
        end
      end else if (b == 0 && e == m_p - 1 && strt_glitch) m_act = 0;
      else if (b == sb && e == h + 3) m_act = 0;
      else begin
        if (m_pe && b == DW + 1 && e == m_p - 1) m_pf = par_err;
        m_k++;
      end
    end
  end

  task automatic clear_logs();
    dv_q.delete(); pe_q.delete(); fe_q.delete(); ds_q.delete();
    fe_edge = -1; fe_bit = -1;
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // Drives one frame on the line; at offset abort_k the bench pulls rst low for one cycle.
  task automatic send_frame(input logic [7:0] d, input int abort_k, output int t0);
    logic [10:0] bits;
    int nb, p;
    p  = int'(prescale);
    nb = par_en ? 11 : 10;
    bits = '1;
    bits[0] = 1'b0;
    bits[8:1] = d;
    bits[9] = par_en ? ^d : 1'b1;
    t0 = cyc;
    for (int k = 0; k < nb * p; k++) begin
      rx_in = bits[k / p];
      if (k == abort_k) begin rst = 1'b0; rx_in = 1'b1; end
      @(posedge clk); #1;
      rst = 1'b1;
      if (k == abort_k) break;
    end
    rx_in = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got time %0t expected finish", $time);
    $fatal(1);
  end

  initial begin
    int t0, t1;
    logic [18:0] outs;
    rst = 1'b0;
    idle_cycles(3);
    rst = 1'b1;
    checking = 1'b1;
    @(negedge clk);
    outs = {edge_count, bit_count, edge_cnt_en, dat_samp_en, strt_chk_en, par_chk_en,
            stp_chk_en, deser_en, data_valid, parity_error, framing_error};
    check("reset_outputs", 32'(outs), 32'd0);
    @(posedge clk); #1;
    idle_cycles(3);

    // P=8, no parity, clean frame
    clear_logs();
    prescale = 6'd8; par_en = 1'b0;
    send_frame(8'hA5, -1, t0);
    idle_cycles(4);
    check("t1_dv_count", dv_q.size(), 1);
    if (dv_q.size() > 0) check("t1_dv_latency", dv_q[0] - t0, 79);
    check("t1_deser_count", ds_q.size(), 8);
    if (ds_q.size() > 0) check("t1_first_deser", ds_q[0] - t0, 14);
    for (int i = 1; i < ds_q.size(); i++) check("t1_deser_spacing", ds_q[i] - ds_q[i-1], 8);
    check("t1_err_pulses", pe_q.size() + fe_q.size(), 0);

    // P=16 with parity, parity checker reports a failure
    clear_logs();
    prescale = 6'd16; par_en = 1'b1; par_err = 1'b1;
    send_frame(8'h5A, -1, t0);
    par_err = 1'b0;
    idle_cycles(4);
    check("t2_pe_count", pe_q.size(), 1);
    if (pe_q.size() > 0) check("t2_pe_latency", pe_q[0] - t0, 171);
    check("t2_dv_count", dv_q.size(), 0);
    check("t2_fe_count", fe_q.size(), 0);
    @(negedge clk);
    check("t2_idle_after", edge_cnt_en, 0);
    @(posedge clk); #1;
    par_en = 1'b0;

    // P=32, stop checker reports a failure
    clear_logs();
    prescale = 6'd32; stop_err = 1'b1;
    send_frame(8'h81, -1, t0);
    stop_err = 1'b0;
    idle_cycles(4);
    check("t3_fe_count", fe_q.size(), 1);
    if (fe_q.size() > 0) check("t3_fe_latency", fe_q[0] - t0, 307);
    check("t3_fe_edge", fe_edge, 19);
    check("t3_fe_bit", fe_bit, 9);
    check("t3_dv_count", dv_q.size(), 0);

    // P=16 start glitch
    clear_logs();
    prescale = 6'd16; strt_glitch = 1'b1;
    t0 = cyc;
    rx_in = 1'b0;
    idle_cycles(3);
    rx_in = 1'b1;
    idle_cycles(12);
    @(negedge clk);
    check("t4_edge15", {edge_cnt_en, edge_count}, {1'b1, 5'd15});
    @(posedge clk); #1;
    @(negedge clk);
    check("t4_back_idle", {edge_cnt_en, strt_chk_en}, 2'b00);
    @(posedge clk); #1;
    strt_glitch = 1'b0;
    idle_cycles(10);
    check("t4_no_pulse", dv_q.size() + pe_q.size() + fe_q.size(), 0);
    check("t4_no_deser", ds_q.size(), 0);

    // P=8 back-to-back frames
    clear_logs();
    prescale = 6'd8;
    send_frame(8'h3C, -1, t0);
    send_frame(8'hC3, -1, t1);
    idle_cycles(4);
    check("t5_second_start", t1 - t0, 80);
    check("t5_dv_count", dv_q.size(), 2);
    if (dv_q.size() == 2) begin
      check("t5_dv_first", dv_q[0] - t0, 79);
      check("t5_dv_spacing", dv_q[1] - dv_q[0], 80);
    end

    // reset in the middle of data bit 4, then a clean frame
    clear_logs();
    send_frame(8'hA5, 34, t0);
    @(negedge clk);
    outs = {edge_count, bit_count, edge_cnt_en, dat_samp_en, strt_chk_en, par_chk_en,
            stp_chk_en, deser_en, data_valid, parity_error, framing_error};
    check("t6_after_reset", 32'(outs), 32'd0);
    @(posedge clk); #1;
    idle_cycles(3);
    check("t6_no_pulse_aborted", dv_q.size() + pe_q.size() + fe_q.size(), 0);
    send_frame(8'h69, -1, t0);
    idle_cycles(4);
    check("t6_dv_count", dv_q.size(), 1);
    if (dv_q.size() > 0) check("t6_dv_latency", dv_q[0] - t0, 79);

    checking = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
